// File: rtl/mul8_acc.sv
// Block accumulator for 16-bit products from an 8x8 multiplier: sums cfg_len products
// (or until flush), then holds the result until accepted. Optional macro MUL8_ACC_SAT_EN
// makes the accumulator saturate on overflow instead of wrapping.
module mul8_acc #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      p_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_o,
    output logic [8:0]       cnt_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] MAXV = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [8:0]       len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   p_wide;
    logic [ACC_W:0]   sum_w;
    logic             carry;
    logic [8:0]       cnt_inc;
    logic [8:0]       len_first;

    assign accept    = in_valid & in_ready;
    assign p_wide    = {{(ACC_W-15){1'b0}}, p_in};
    assign sum_w     = {1'b0, acc_q} + p_wide;
    assign carry     = sum_w[ACC_W];
    assign cnt_inc   = cnt_q + 9'd1;
    // A programmed length of 0 stands for a full 256-product block.
    assign len_first = (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (len_first == 9'd1 || flush) ? HOLD : ACC;
            ACC: begin
                if (flush)                          state_d = HOLD;
                else if (accept && cnt_inc == len_q) state_d = HOLD;
            end
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        sum_o     = out_valid ? acc_q : '0;
        cnt_o     = out_valid ? cnt_q : 9'd0;
        ovf_o     = out_valid ? ovf_q : 1'b0;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (state_q == IDLE) begin
                acc_d = p_wide[ACC_W-1:0];
                cnt_d = 9'd1;
                len_d = len_first;
                ovf_d = 1'b0;
            end else begin
`ifdef MUL8_ACC_SAT_EN
                // Once clamped at MAXV any nonzero product carries again, so it stays clamped.
                acc_d = carry ? MAXV : sum_w[ACC_W-1:0];
`else
                acc_d = sum_w[ACC_W-1:0];
`endif
                cnt_d = cnt_inc;
                ovf_d = ovf_q | carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= 9'd0;
            len_q <= 9'd0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

endmodule
